muldiv_seq_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit with its sequencing FSM, sitting beside the main ALU in EX.
//  EX raises start_i for M-extension ops (opcode OP, funct7=0000001); unit stalls pipeline until result is ready.

---
 rtl/core_pkg.sv | 25 ++
 rtl/muldiv_seq_unit_if.sv | 22 ++
 rtl/md_iter_datapath.sv | 42 ++++
 rtl/muldiv_seq_unit.sv | 127 ++++++++++++
 tb/tb_muldiv_seq_unit.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared M-extension op encodings, unit state encoding and decode constants
package core_pkg;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [2:0] {
      MD_IDLE,
      MD_PREP,
      MD_CALC,
      MD_FIX,
      MD_DONE
   } md_state_e;

endpackage

// File: rtl/muldiv_seq_unit_if.sv
// muldiv_seq_unit_if: EX-side request/response bundle of the multiply/divide unit
interface muldiv_seq_unit_if #(parameter int XLEN = 32);
   import core_pkg::*;
   logic            start_i;
   md_op_e          md_op_i;
   logic [XLEN-1:0] rs1_data_i;
   logic [XLEN-1:0] rs2_data_i;
   logic            flush_i;
   logic            result_ready_i;
   logic            busy_o;
   logic            stall_o;
   logic            result_valid_o;
   logic [XLEN-1:0] result_o;
   modport master (
      output start_i, md_op_i, rs1_data_i, rs2_data_i, flush_i, result_ready_i,
      input  busy_o, stall_o, result_valid_o, result_o
   );
   modport slave (
      input  start_i, md_op_i, rs1_data_i, rs2_data_i, flush_i, result_ready_i,
      output busy_o, stall_o, result_valid_o, result_o
   );
endinterface

// File: rtl/md_iter_datapath.sv
// md_iter_datapath: unsigned shift-add multiply / restoring divide, one step per enabled cycle
module md_iter_datapath #(parameter int XLEN = 32) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load,
   input  logic              step,
   input  logic              div_mode,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   output logic [2*XLEN-1:0] prod,
   output logic [XLEN-1:0]   rem_out
);
   logic [XLEN-1:0] opnd;
   logic [XLEN:0]   rem;
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   trial;
   assign rem_out = rem[XLEN-1:0];
   // one multiply accumulate or one trial subtraction per cycle
   always_comb begin
      mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
      shifted = {rem[XLEN-1:0], prod[XLEN-1]};
      trial   = shifted - {1'b0, opnd};
   end
   // mul: low half holds multiplier; div: low half shifts dividend out, quotient in
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         opnd <= '0;
         prod <= '0;
         rem  <= '0;
      end else if (load) begin
         opnd <= div_mode ? op_b : op_a;
         prod <= {{XLEN{1'b0}}, div_mode ? op_a : op_b};
         rem  <= '0;
      end else if (step && div_mode) begin
         rem            <= trial[XLEN] ? shifted : trial;
         prod[XLEN-1:0] <= {prod[XLEN-2:0], !trial[XLEN]};
      end else if (step) begin
         prod <= {mul_sum, prod[XLEN-1:1]};
      end
   end
endmodule

// File: rtl/muldiv_seq_unit.sv
// muldiv_seq_unit: iterative RV32M multiply/divide with sequencing FSM and pipeline stall
// MULDIV_FAST_MUL_EN: when defined, multiplies finish from PREP with a combinational multiplier
module muldiv_seq_unit import core_pkg::*; #(parameter int XLEN = 32) (
   input  logic             clk_i,
   input  logic             rst_i,
   muldiv_seq_unit_if.slave bus
);
   localparam int CNT_W = $clog2(XLEN);
   md_state_e         state;
   md_op_e            op_q;
   logic [XLEN-1:0]   a_q, b_q;
   logic [CNT_W-1:0]  cnt;
   logic              res_neg, busy_q, valid_q;
   logic [XLEN-1:0]   result_q;
   logic              is_div, sa, sb, neg_a, neg_b, div_zero, div_ovf;
   logic [XLEN-1:0]   a_abs, b_abs, prep_val, fix_val, q_fix, r_fix, rem;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic              fast_hit;
   logic [XLEN-1:0]   fast_val;
   md_iter_datapath #(.XLEN(XLEN)) u_dp (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load     (state == MD_PREP),
      .step     (state == MD_CALC),
      .div_mode (is_div),
      .op_a     (a_abs),
      .op_b     (b_abs),
      .prod     (prod),
      .rem_out  (rem)
   );
   // operand magnitudes, special-case detection and final sign/half selection
   always_comb begin
      is_div   = op_q[2];
      sa       = op_q inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
      sb       = op_q inside {MD_MULH, MD_DIV, MD_REM};
      neg_a    = sa && a_q[XLEN-1];
      neg_b    = sb && b_q[XLEN-1];
      a_abs    = neg_a ? -a_q : a_q;
      b_abs    = neg_b ? -b_q : b_q;
      div_zero = is_div && (b_q == '0);
      div_ovf  = (op_q == MD_DIV || op_q == MD_REM) && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (&b_q);
      prep_val = op_q[1] ? (div_zero ? a_q : '0) : (div_zero ? '1 : a_q);
      prod_fix = res_neg ? -prod : prod;
      q_fix    = res_neg ? -prod[XLEN-1:0] : prod[XLEN-1:0];
      r_fix    = res_neg ? -rem : rem;
      fix_val  = is_div ? (op_q[1] ? r_fix : q_fix)
                        : (op_q == MD_MUL ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);
   end
`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN+1:0] fa, fb, fp;
   // sign-extend to XLEN+1 significant bits so one multiplier covers all four variants
   always_comb begin
      fa       = {{(XLEN+2){sa && a_q[XLEN-1]}}, a_q};
      fb       = {{(XLEN+2){sb && b_q[XLEN-1]}}, b_q};
      fp       = fa * fb;
      fast_val = op_q == MD_MUL ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
      fast_hit = !is_div;
   end
`else
   assign fast_hit = 1'b0;
   assign fast_val = '0;
`endif
   assign bus.busy_o         = busy_q;
   assign bus.result_valid_o = valid_q;
   assign bus.result_o       = result_q;
   assign bus.stall_o        = (state == MD_IDLE && bus.start_i && !bus.flush_i) ||
                               (state inside {MD_PREP, MD_CALC, MD_FIX});
   // sequencing FSM; flush overrides every state and drops any held result
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= MD_IDLE;
         op_q     <= MD_MUL;
         a_q      <= '0;
         b_q      <= '0;
         cnt      <= '0;
         res_neg  <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= '0;
      end else if (bus.flush_i) begin
         state    <= MD_IDLE;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= '0;
      end else begin
         case (state)
            MD_IDLE: if (bus.start_i) begin
               op_q   <= bus.md_op_i;
               a_q    <= bus.rs1_data_i;
               b_q    <= bus.rs2_data_i;
               busy_q <= 1'b1;
               state  <= MD_PREP;
            end
            MD_PREP: begin
               res_neg <= (is_div && op_q[1]) ? neg_a : neg_a ^ neg_b;
               if (div_zero || div_ovf) begin
                  result_q <= prep_val;
                  valid_q  <= 1'b1;
                  state    <= MD_DONE;
               end else if (fast_hit) begin
                  result_q <= fast_val;
                  valid_q  <= 1'b1;
                  state    <= MD_DONE;
               end else begin
                  cnt   <= CNT_W'(XLEN-1);
                  state <= MD_CALC;
               end
            end
            MD_CALC: begin
               cnt <= cnt - 1'b1;
               if (cnt == '0) state <= MD_FIX;
            end
            MD_FIX: begin
               result_q <= fix_val;
               valid_q  <= 1'b1;
               state    <= MD_DONE;
            end
            MD_DONE: if (bus.result_ready_i) begin
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
               state   <= MD_IDLE;
            end
            default: state <= MD_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_seq_unit.sv
// tb_muldiv_seq_unit: directed checks of results, latency, hold, flush and reset of muldiv_seq_unit
module tb_muldiv_seq_unit;
   import core_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   muldiv_seq_unit_if #(.XLEN(32)) bus ();
   muldiv_seq_unit #(.XLEN(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic do_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
      @(negedge clk);
      bus.start_i = 1'b1; bus.md_op_i = op; bus.rs1_data_i = a; bus.rs2_data_i = b;
      lat = -1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         bus.start_i = 1'b0;
         if (bus.result_valid_o) begin lat = c; break; end
      end
      res = bus.result_o;
      bus.result_ready_i = 1'b1;
      @(negedge clk);
      bus.result_ready_i = 1'b0;
   endtask

   task automatic check_op(input string name, input md_op_e op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      logic [31:0] res;
      int lat;
      do_op(op, a, b, res, lat);
      checks++;
      if (res !== exp) begin errors++; $display("FAIL %s result got %h want %h", name, res, exp); end
      checks++;
      if (lat != exp_lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat); end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.busy_o, bus.stall_o, bus.result_valid_o, bus.result_o} !== 35'd0) begin
         errors++; $display("FAIL reset_state got b%b s%b v%b r%h want 0", bus.busy_o, bus.stall_o, bus.result_valid_o, bus.result_o);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_release busy got %b want 0", bus.busy_o); end
   endtask

   task automatic test_stall_start;
      @(negedge clk);
      bus.start_i = 1'b1; bus.md_op_i = MD_DIVU; bus.rs1_data_i = 32'd9; bus.rs2_data_i = 32'd3;
      #1;
      checks++;
      if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL stall_on_start got %b want 1", bus.stall_o); end
      @(negedge clk);
      bus.start_i = 1'b0;
      checks++;
      if (bus.stall_o !== 1'b1 || bus.busy_o !== 1'b1) begin
         errors++; $display("FAIL stall_in_prep got s%b b%b want 1 1", bus.stall_o, bus.busy_o);
      end
      for (int c = 0; c < 40 && !bus.result_valid_o; c++) @(negedge clk);
      bus.result_ready_i = 1'b1;
      @(negedge clk);
      bus.result_ready_i = 1'b0;
   endtask

   task automatic test_mul;
      check_op("mul_7_m3", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
      check_op("mulhu_ff", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
      check_op("mulh_ff", MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 35);
      check_op("mulhsu_ff", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
   endtask

   task automatic test_div;
      check_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
      check_op("rem_m7_2", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
      check_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd14, 35);
      check_op("remu_100_7", MD_REMU, 32'd100, 32'd7, 32'd2, 35);
   endtask

   task automatic test_special;
      check_op("divu_by0", MD_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 2);
      check_op("remu_by0", MD_REMU, 32'd100, 32'd0, 32'd100, 2);
      check_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
      check_op("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);
   endtask

   task automatic test_hold;
      int seen = 0;
      @(negedge clk);
      bus.start_i = 1'b1; bus.md_op_i = MD_DIVU; bus.rs1_data_i = 32'd100; bus.rs2_data_i = 32'd7;
      for (int c = 1; c <= 100 && !bus.result_valid_o; c++) begin @(negedge clk); bus.start_i = 1'b0; end
      for (int c = 0; c < 5; c++) begin
         bus.start_i = 1'b1; bus.md_op_i = MD_MUL; bus.rs1_data_i = 32'd3; bus.rs2_data_i = 32'd3;
         @(negedge clk);
         checks++;
         if (bus.result_valid_o !== 1'b1 || bus.result_o !== 32'd14 || bus.stall_o !== 1'b0) begin
            errors++; $display("FAIL hold_%0d got v%b r%h s%b want v1 r0000000e s0", c, bus.result_valid_o, bus.result_o, bus.stall_o);
         end
         seen++;
      end
      bus.start_i = 1'b0;
      bus.result_ready_i = 1'b1;
      @(negedge clk);
      bus.result_ready_i = 1'b0;
      checks++;
      if (bus.busy_o !== 1'b0 || bus.result_valid_o !== 1'b0 || seen != 5) begin
         errors++; $display("FAIL hold_release got b%b v%b want 0 0", bus.busy_o, bus.result_valid_o);
      end
   endtask

   task automatic test_flush;
      int got_valid = 0;
      @(negedge clk);
      bus.start_i = 1'b1; bus.md_op_i = MD_DIV; bus.rs1_data_i = 32'd1000; bus.rs2_data_i = 32'd3;
      for (int c = 1; c <= 10; c++) begin @(negedge clk); bus.start_i = 1'b0; end
      bus.flush_i = 1'b1;
      @(negedge clk);
      bus.flush_i = 1'b0;
      checks++;
      if (bus.busy_o !== 1'b0 || bus.result_valid_o !== 1'b0 || bus.stall_o !== 1'b0) begin
         errors++; $display("FAIL flush_idle got b%b v%b s%b want 0 0 0", bus.busy_o, bus.result_valid_o, bus.stall_o);
      end
      for (int c = 0; c < 40; c++) begin @(negedge clk); if (bus.result_valid_o) got_valid++; end
      checks++;
      if (got_valid != 0) begin errors++; $display("FAIL flush_no_result got %0d valid cycles want 0", got_valid); end
      bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.md_op_i = MD_MUL;
      #1;
      checks++;
      if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL flush_start_stall got %b want 0", bus.stall_o); end
      @(negedge clk);
      bus.start_i = 1'b0; bus.flush_i = 1'b0;
      checks++;
      if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL flush_start_busy got %b want 0", bus.busy_o); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] res;
      int lat;
      check_op("pre_reset", MD_DIVU, 32'd50, 32'd5, 32'd10, 35);
      @(negedge clk);
      bus.start_i = 1'b1; bus.md_op_i = MD_MUL; bus.rs1_data_i = 32'd5; bus.rs2_data_i = 32'd6;
      for (int c = 1; c <= 10; c++) begin @(negedge clk); bus.start_i = 1'b0; end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.busy_o, bus.stall_o, bus.result_valid_o, bus.result_o} !== 35'd0) begin
         errors++; $display("FAIL reset_mid got b%b s%b v%b r%h want 0", bus.busy_o, bus.stall_o, bus.result_valid_o, bus.result_o);
      end
      @(negedge clk);
      rst = 1'b0;
      do_op(MD_MUL, 32'd5, 32'd6, res, lat);
      checks++;
      if (res !== 32'd30) begin errors++; $display("FAIL after_reset_mul got %h want %h", res, 32'd30); end
   endtask

   initial begin
      bus.start_i = 1'b0; bus.md_op_i = MD_MUL; bus.rs1_data_i = '0; bus.rs2_data_i = '0;
      bus.flush_i = 1'b0; bus.result_ready_i = 1'b0;
      test_reset;
      test_stall_start;
      test_mul;
      test_div;
      test_special;
      test_hold;
      test_flush;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
